soi_change_logger: RTL and testbench
====================================

# soi_change_logger

Downstream observer stage for a signal of interest (SOI) such as a toggling testbench register. It samples the SOI every clock and detects value changes. Each change is recorded as a {value, timestamp} event in a small show-ahead FIFO, which a host-side DPI poller drains one entry at a time. Per-SOI statistics are kept alongside: a change count, a drop count and a sticky overflow flag.

## Interface
Parameters:
- WIDTH, 1, SOI width in bits.
- TS_WIDTH, 32, timestamp counter width.
- DEPTH, 8, event FIFO depth; must be a power of two and at least 2.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- soi_in  in  WIDTH  signal being observed, sampled on every rising edge.
- enable  in  1  logging enable.
- rd_en  in  1  pop request for the FIFO head.
- clr_ovf  in  1  clears overflow and drop_count.
- rd_valid  out  1  FIFO not empty; head fields are valid.
- rd_value  out  WIDTH  SOI value of the head event.
- rd_ts  out  TS_WIDTH  timestamp of the head event.
- level  out  $clog2(DEPTH)+1  number of stored events.
- change_count  out  16  changes detected, including dropped ones; saturating.
- drop_count  out  16  events lost to a full FIFO; saturating.
- overflow  out  1  sticky flag, set by any drop.

## Operation
- Timestamp counter ts: 0 in reset, then +1 every cycle regardless of enable. Wraps modulo 2^TS_WIDTH with no flag.
- FSM states IDLE, ARM, RUN; reset state is IDLE.
  - IDLE -> ARM when enable=1.
  - ARM: latch prev <= soi_in. No event is generated. Go to RUN if enable=1, else IDLE.
  - RUN, enable=0 -> IDLE. No event is generated on this cycle.
  - RUN, enable=1: if soi_in != prev, a change is detected. On a change: prev <= soi_in, change_count += 1 (saturating at 0xFFFF), and an event {soi_in, ts} is pushed using the pre-increment ts.
- Re-enabling always passes through ARM, so a value change that happens while disabled never produces an event.
- FIFO behaviour:
  - Show-ahead: rd_valid = (level != 0), and rd_value/rd_ts show the head entry combinationally from storage.
  - A pop happens when rd_en=1 and rd_valid=1. rd_en with an empty FIFO is ignored.
  - A push happens when a change is detected and either level < DEPTH, or level == DEPTH and a pop occurs on the same cycle.
  - A push with a simultaneous pop leaves level unchanged.
  - A change that cannot be pushed is dropped: drop_count += 1 (saturating) and overflow <= 1. The change is still counted in change_count, and prev still updates.
- clr_ovf: on the next edge overflow <= 0 and drop_count <= 0. If a drop occurs on the same cycle, the drop wins: overflow=1 and drop_count=1.
- Read and write pointers are log2(DEPTH) bits wide and wrap naturally.

## Timing
- Reset values: rd_valid=0, level=0, change_count=0, drop_count=0, overflow=0, ts=0, prev=0, FSM=IDLE. rd_value and rd_ts are don't-care while rd_valid=0.
- Reset asserted mid-operation flushes the FIFO and clears all counters and the FSM at the next edge. Pending events are discarded.
- Latency: a change sampled at edge N gives rd_valid=1 and the new head contents after edge N (visible in cycle N+1). level and change_count update at the same edge.
- Pop: after the edge with rd_en=1, the head advances and level decrements at that edge.
- Throughput: one event per cycle can be accepted and one popped per cycle concurrently.
- First enable: enable rising at edge E puts the FSM in ARM at E. The earliest event can come from a change sampled at edge E+2.

## Test plan
- Reset, enable, soi_in toggling every cycle from 1 (WIDTH=1), no reads. Required: events alternate value 0/1 with consecutive ts values; level saturates at 8; overflow=1; drop_count and change_count keep incrementing.
- Single change: soi_in 0->1 sampled at ts=20 while in RUN. Required: rd_valid=1 in the next cycle, rd_value=1, rd_ts=20, level=1. One rd_en pulse then gives rd_valid=0 and level=0.
- Full FIFO (level=8) with a change and rd_en on the same cycle. Required: level stays 8, drop_count unchanged, overflow stays 0, and the new event lands at the tail.
- Disable in RUN, change soi_in 0->1 while disabled, then re-enable. Required: no event, change_count unchanged. A subsequent 1->0 change is logged with value 0.
- TS_WIDTH=4: event at ts=15 followed by an event 2 cycles later. Required: the second event has rd_ts=1.
- With overflow=1 and drop_count=3, assert rd_n... that is, pulse rst_n=0 for 1 cycle. Required: everything is cleared, rd_valid=0, ts=0. Separately, clr_ovf together with a simultaneous drop gives overflow=1 and drop_count=1.

Source files
------------

// File: rtl/soi_change_logger.sv
// Observes a signal of interest, logs each value change as a {value, timestamp} event
// into a show-ahead FIFO, and keeps change/drop statistics with a sticky overflow flag.
module soi_change_logger #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned TS_WIDTH = 32,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         soi_in,
    input  logic                     enable,
    input  logic                     rd_en,
    input  logic                     clr_ovf,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_value,
    output logic [TS_WIDTH-1:0]      rd_ts,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              change_count,
    output logic [15:0]              drop_count,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FullLevel = LW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StArm, StRun} state_e;

    state_e                r_state;
    state_e                w_state_d;
    logic [TS_WIDTH-1:0]   r_ts;
    logic [WIDTH-1:0]      r_prev;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic [15:0]           r_change_count;
    logic [15:0]           r_drop_count;
    logic                  r_overflow;
    logic [WIDTH-1:0]      r_mem_value [DEPTH];
    logic [TS_WIDTH-1:0]   r_mem_ts    [DEPTH];

    logic w_latch;
    logic w_change;
    logic w_pop;
    logic w_push;
    logic w_drop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // ARM only captures the baseline so a change made while disabled never logs.
    always_comb begin
        w_state_d = r_state;
        w_latch   = 1'b0;
        w_change  = 1'b0;
        case (r_state)
            StIdle: begin
                if (enable) w_state_d = StArm;
            end
            StArm: begin
                w_latch   = 1'b1;
                w_state_d = enable ? StRun : StIdle;
            end
            StRun: begin
                if (!enable) begin
                    w_state_d = StIdle;
                end else begin
                    w_change = (soi_in != r_prev);
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign w_pop  = rd_en && (r_level != '0);
    assign w_push = w_change && ((r_level != FullLevel) || w_pop);
    assign w_drop = w_change && !w_push;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ts           <= '0;
            r_prev         <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_change_count <= '0;
            r_drop_count   <= '0;
            r_overflow     <= 1'b0;
        end else begin
            r_ts <= r_ts + TS_WIDTH'(1);
            if (w_latch || w_change) r_prev <= soi_in;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_change && !(&r_change_count)) begin
                r_change_count <= r_change_count + 16'd1;
            end
            // A drop on the same edge as a clear takes precedence.
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (clr_ovf) begin
                    r_drop_count <= 16'd1;
                end else if (!(&r_drop_count)) begin
                    r_drop_count <= r_drop_count + 16'd1;
                end
            end else if (clr_ovf) begin
                r_overflow   <= 1'b0;
                r_drop_count <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_value[r_wr_ptr] <= soi_in;
            r_mem_ts[r_wr_ptr]    <= r_ts;
        end
    end

    assign rd_valid     = (r_level != '0);
    assign rd_value     = r_mem_value[r_rd_ptr];
    assign rd_ts        = r_mem_ts[r_rd_ptr];
    assign level        = r_level;
    assign change_count = r_change_count;
    assign drop_count   = r_drop_count;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_soi_change_logger.sv
// Directed bench for soi_change_logger: a default instance plus a TS_WIDTH=4 instance
// for timestamp wrap.
module tb_soi_change_logger;

    logic        clk;
    logic        rst_n;
    logic        soi_in;
    logic        enable;
    logic        rd_en;
    logic        clr_ovf;
    logic        rd_valid;
    logic        rd_value;
    logic [31:0] rd_ts;
    logic [3:0]  level;
    logic [15:0] change_count;
    logic [15:0] drop_count;
    logic        overflow;

    logic        soi4;
    logic        en4;
    logic        rd4;
    logic        clr4;
    logic        rd_valid4;
    logic        rd_value4;
    logic [3:0]  rd_ts4;
    logic [3:0]  level4;
    logic [15:0] cc4;
    logic [15:0] dc4;
    logic        ovf4;

    int unsigned n_cmp;
    int unsigned n_err;
    int unsigned tb_ts;
    int unsigned t0;
    int unsigned ts_new;
    int unsigned ts_ev;

    soi_change_logger #(.WIDTH(1), .TS_WIDTH(32), .DEPTH(8)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .soi_in       (soi_in),
        .enable       (enable),
        .rd_en        (rd_en),
        .clr_ovf      (clr_ovf),
        .rd_valid     (rd_valid),
        .rd_value     (rd_value),
        .rd_ts        (rd_ts),
        .level        (level),
        .change_count (change_count),
        .drop_count   (drop_count),
        .overflow     (overflow)
    );

    soi_change_logger #(.WIDTH(1), .TS_WIDTH(4), .DEPTH(8)) u_ts4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .soi_in       (soi4),
        .enable       (en4),
        .rd_en        (rd4),
        .clr_ovf      (clr4),
        .rd_valid     (rd_valid4),
        .rd_value     (rd_value4),
        .rd_ts        (rd_ts4),
        .level        (level4),
        .change_count (cc4),
        .drop_count   (dc4),
        .overflow     (ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // tb_ts mirrors the design's timestamp: value held before the next edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) tb_ts = 0;
        else        tb_ts = tb_ts + 1;
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; tb_ts = 0;
        rst_n = 1'b0; enable = 1'b0; soi_in = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
        en4 = 1'b0; soi4 = 1'b0; rd4 = 1'b0; clr4 = 1'b0;
        repeat (3) tick();
        chk("rst_valid", rd_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_cc", change_count, 0);
        chk("rst_dc", drop_count, 0);
        chk("rst_ovf", overflow, 0);

        // Enable both instances; ts4 sees changes at ts 15 and 17 (wraps to 1).
        rst_n = 1'b1; enable = 1'b1; en4 = 1'b1;
        while (tb_ts < 20) begin
            if (tb_ts == 15) soi4 = 1'b1;
            if (tb_ts == 17) soi4 = 1'b0;
            tick();
        end
        chk("steady_level", level, 0);
        chk("ts4_level", level4, 2);
        chk("ts4_head_val", rd_value4, 1);
        chk("ts4_head_ts", rd_ts4, 15);

        // Single change sampled at ts=20, popping the ts4 head on the same edge.
        soi_in = 1'b1; rd4 = 1'b1;
        tick();
        rd4 = 1'b0;
        chk("single_valid", rd_valid, 1);
        chk("single_val", rd_value, 1);
        chk("single_ts", rd_ts, 20);
        chk("single_level", level, 1);
        chk("single_cc", change_count, 1);
        chk("ts4_wrap_val", rd_value4, 0);
        chk("ts4_wrap_ts", rd_ts4, 1);
        chk("ts4_level_pop", level4, 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("single_pop_valid", rd_valid, 0);
        chk("single_pop_level", level, 0);

        // Toggle every cycle, no reads: 8 stored, 2 dropped.
        t0 = tb_ts;
        for (int i = 0; i < 10; i++) begin
            soi_in = ~soi_in;
            tick();
        end
        chk("tog_level", level, 8);
        chk("tog_cc", change_count, 11);
        chk("tog_dc", drop_count, 2);
        chk("tog_ovf", overflow, 1);
        chk("tog_head_val", rd_value, 0);
        chk("tog_head_ts", rd_ts, t0);

        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr_ovf", overflow, 0);
        chk("clr_dc", drop_count, 0);
        chk("clr_level", level, 8);

        // Full FIFO: change plus pop on the same edge.
        ts_new = tb_ts;
        soi_in = ~soi_in;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("fullpp_level", level, 8);
        chk("fullpp_dc", drop_count, 0);
        chk("fullpp_ovf", overflow, 0);
        chk("fullpp_cc", change_count, 12);
        for (int j = 1; j < 8; j++) begin
            chk("drain_val", rd_value, j % 2);
            chk("drain_ts", rd_ts, t0 + j);
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        chk("tail_val", rd_value, 0);
        chk("tail_ts", rd_ts, ts_new);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("drain_empty", rd_valid, 0);

        // Change while disabled is never logged; re-enable goes through ARM.
        enable = 1'b0;
        tick();
        soi_in = 1'b1;
        tick();
        tick();
        chk("dis_level", level, 0);
        enable = 1'b1;
        tick();
        tick();
        chk("reen_level", level, 0);
        chk("reen_cc", change_count, 12);
        ts_ev = tb_ts;
        soi_in = 1'b0;
        tick();
        chk("reen_ev_level", level, 1);
        chk("reen_ev_val", rd_value, 0);
        chk("reen_ev_ts", rd_ts, ts_ev);
        chk("reen_ev_cc", change_count, 13);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;

        // Fill, then clear coincident with a drop: the drop wins.
        for (int i = 0; i < 8; i++) begin
            soi_in = ~soi_in;
            tick();
        end
        chk("fill_level", level, 8);
        soi_in = ~soi_in; clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clrdrop_ovf", overflow, 1);
        chk("clrdrop_dc", drop_count, 1);
        for (int i = 0; i < 2; i++) begin
            soi_in = ~soi_in;
            tick();
        end
        chk("drop3_dc", drop_count, 3);
        chk("drop3_cc", change_count, 24);

        // One-cycle reset mid-operation.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_valid", rd_valid, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_cc", change_count, 0);
        chk("mid_rst_dc", drop_count, 0);
        chk("mid_rst_ovf", overflow, 0);
        tick();
        tick();
        soi_in = ~soi_in;
        tick();
        chk("post_rst_level", level, 1);
        chk("post_rst_ts", rd_ts, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
